buzzer_lockout: RTL and testbench

BUZZER_LOCKOUT -- requirements
Module: buzzer_lockout

---
 rtl/buzzer_lockout_pkg.sv | 47 ++++
 rtl/buzzer_lockout_if.sv | 23 ++
 rtl/buzzer_lockout_button_debounce.sv | 53 +++++
 rtl/buzzer_lockout.sv | 118 +++++++++++
 tb/tb_buzzer_lockout.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/buzzer_lockout_pkg.sv
// Shared types, constants and arbitration helpers for the quiz buzzer lockout.
package buzzer_lockout_pkg;

    localparam int NUM_PLAYERS         = 4;
    localparam int PTR_W               = $clog2(NUM_PLAYERS);
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    typedef logic [NUM_PLAYERS-1:0] pvec_t;

    // Scan from the farthest slot to the nearest so the player closest to ptr wins.
    function automatic pvec_t rr_pick(input pvec_t req, input logic [PTR_W-1:0] ptr);
        pvec_t            grant;
        logic [PTR_W-1:0] idx;
        grant = '0;
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end else begin
                grant = grant;
            end
        end
        return grant;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_idx(input pvec_t oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (oh[k]) begin
                idx = PTR_W'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/buzzer_lockout_if.sv
// Player buttons, quizmaster controls and status outputs of the buzzer lockout.
interface buzzer_lockout_if;
    import buzzer_lockout_pkg::*;

    pvec_t buttons;
    logic  start;
    logic  clear;
    pvec_t player;
    logic  armed;
    logic  locked;
    pvec_t penalty;
    logic  timeout;

    modport master (
        output buttons, start, clear,
        input  player, armed, locked, penalty, timeout
    );

    modport slave (
        input  buttons, start, clear,
        output player, armed, locked, penalty, timeout
    );
endinterface

// File: rtl/buzzer_lockout_button_debounce.sv
// Two-flop synchronizer plus counting debouncer; emits a one-cycle pulse on each debounced press.
module button_debounce
    import buzzer_lockout_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample equal to the current level restarts the run of differing samples.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/buzzer_lockout.sv
// Quiz buzzer lockout: first eligible debounced press wins, false starts are penalized.
module buzzer_lockout
    import buzzer_lockout_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    buzzer_lockout_if.slave   bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q, state_d;
    pvec_t            player_q, player_d;
    pvec_t            penalty_q, penalty_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             armed_q, armed_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    pvec_t            press_s, eligible_s, grant_s;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (bus.buttons[g]),
            .rise_o (press_s[g])
        );
    end

    assign eligible_s = press_s & ~penalty_q;
    assign grant_s    = rr_pick(eligible_s, ptr_q);

    // Round FSM; clear overrides everything, and a winner beats an expiring timer.
    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        penalty_d = penalty_q;
        ptr_d     = ptr_q;
        tmr_d     = tmr_q;
        timeout_d = 1'b0;
        if (bus.clear) begin
            state_d   = ST_IDLE;
            player_d  = '0;
            penalty_d = '0;
            tmr_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    penalty_d = penalty_q | press_s;
                    if (bus.start) begin
                        state_d  = ST_ARMED;
                        player_d = '0;
                        tmr_d    = TMR_W'(TIMEOUT_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (grant_s != '0) begin
                        state_d  = ST_LOCKED;
                        player_d = grant_s;
                        ptr_d    = onehot_idx(grant_s) + PTR_W'(1);
                        tmr_d    = '0;
                    end else if (tmr_q == '0) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        penalty_d = '0;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d   = ST_IDLE;
                    player_d  = '0;
                    penalty_d = '0;
                    tmr_d     = '0;
                end
            endcase
        end
        armed_d  = (state_d == ST_ARMED);
        locked_d = (state_d == ST_LOCKED);
    end

    // Round state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            player_q  <= '0;
            penalty_q <= '0;
            ptr_q     <= '0;
            tmr_q     <= '0;
            armed_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            penalty_q <= penalty_d;
            ptr_q     <= ptr_d;
            tmr_q     <= tmr_d;
            armed_q   <= armed_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.player  = player_q;
    assign bus.penalty = penalty_q;
    assign bus.armed   = armed_q;
    assign bus.locked  = locked_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_buzzer_lockout.sv
// Segment-table bench for buzzer_lockout with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=10.
module tb_buzzer_lockout;
    typedef struct {
        logic [3:0]  btn;
        logic        start;
        logic        clear;
        int          n;
        logic [10:0] exp;   // {player, armed, locked, penalty, timeout}
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t        tbl[$];
    logic [10:0] sb_q[$];

    buzzer_lockout_if bus();

    buzzer_lockout #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got time %0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic [3:0] b, input logic s, input logic c, input int n,
                                input logic [3:0] pl, input logic ar, input logic lk,
                                input logic [3:0] pen, input logic to);
        vec_t v;
        v.btn   = b;
        v.start = s;
        v.clear = c;
        v.n     = n;
        v.exp   = {pl, ar, lk, pen, to};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {bus.player, bus.armed, bus.locked, bus.penalty, bus.timeout};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: {player,armed,locked,penalty,timeout} got %b required %b", name, act, exp);
        end
        total++;
        if ($countones(bus.player) > 1) begin
            bad++;
            $display("FAIL %s_onehot: player got %b required at most one bit set", name, bus.player);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.buttons = tbl[i].btn;
            bus.start   = tbl[i].start;
            bus.clear   = tbl[i].clear;
            sb_q.push_back(tbl[i].exp);
            repeat (tbl[i].n) @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), sb_q.pop_front());
        end
        tbl.delete();
    endtask

    task automatic do_reset(input logic [3:0] hold_btn);
        bus.start   = 1'b0;
        bus.clear   = 1'b0;
        bus.buttons = hold_btn;
        #2 rst_n = 1'b0;
        #1 check("async_reset", 11'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        bus.buttons = 4'b0000;
        bus.start   = 1'b0;
        bus.clear   = 1'b0;
        do_reset(4'b0000);

        // Single press latency, hold in LOCKED, clear
        add(4'b0000, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0001, 1'b0, 1'b0, 6,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0001, 1'b0, 1'b0, 1,  4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0);
        add(4'b0001, 1'b1, 1'b0, 3,  4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 12, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b1, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        // False start by player 2, then player 2 ignored and player 1 wins
        add(4'b0100, 1'b0, 1'b0, 6,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0100, 1'b0, 1'b0, 1,  4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 8,  4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0);
        add(4'b0000, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0);
        add(4'b0100, 1'b0, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0);
        add(4'b0110, 1'b0, 1'b0, 6,  4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0);
        add(4'b0110, 1'b0, 1'b0, 1,  4'b0010, 1'b0, 1'b1, 4'b0100, 1'b0);
        add(4'b0000, 1'b0, 1'b1, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 8,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        run_table("latency_penalty");
        do_reset(4'b0000);

        // Round-robin: pointer 0 picks 0, then pointer 1 skips to 2
        add(4'b0101, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0101, 1'b0, 1'b0, 5,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0101, 1'b0, 1'b0, 1,  4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b1, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 8,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0101, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0101, 1'b0, 1'b0, 6,  4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b1, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 8,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        // Two-cycle glitch is filtered, round then times out
        add(4'b0000, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b1000, 1'b0, 1'b0, 2,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 7,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        add(4'b0000, 1'b0, 1'b0, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        // Timeout after exactly 10 armed cycles also clears penalty
        add(4'b0001, 1'b0, 1'b0, 7,  4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 8,  4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        add(4'b0000, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 9,  4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        add(4'b0000, 1'b0, 1'b0, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        // Clear coincident with a press event, then a normal lock
        add(4'b0000, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0010, 1'b0, 1'b0, 6,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0010, 1'b0, 1'b1, 1,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0010, 1'b0, 1'b0, 3,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 8,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 1'b0, 1,  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        add(4'b0010, 1'b0, 1'b0, 7,  4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0);
        run_table("rr_glitch_timeout_clear");

        // Reset while LOCKED with player 1 still held: outputs drop at once
        do_reset(4'b0010);
        // Held button yields exactly one press event after release
        add(4'b0010, 1'b0, 1'b0, 6,  4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'b0010, 1'b0, 1'b0, 1,  4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0);
        add(4'b0010, 1'b0, 1'b0, 5,  4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0);
        run_table("held_through_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
